// File: rtl/fc_argmax_reader.sv
// fc_argmax_reader: captures the FC layer's logit vector when its done flag
// rises, scans it one entry per cycle for the sign-magnitude maximum, and
// offers the winning class index and score on a valid/ready handshake.
module fc_argmax_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int NODES      = 10,
    parameter int IDX_WIDTH  = 4,
    parameter int DROP_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        done_flag,
    input  logic [DATA_WIDTH*NODES-1:0] logits,
    output logic                        class_valid,
    input  logic                        class_ready,
    output logic [IDX_WIDTH-1:0]        class_idx,
    output logic [DATA_WIDTH-1:0]       class_score,
    output logic                        busy,
    output logic [DROP_WIDTH-1:0]       drop_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NODES - 1);

    logic [1:0]                        state_q,    state_d;
    logic                              done_prev_q;
    logic [NODES-1:0][DATA_WIDTH-1:0]  cap_q,      cap_d;
    logic [IDX_WIDTH-1:0]              scan_idx_q, scan_idx_d;
    logic [IDX_WIDTH-1:0]              best_idx_q, best_idx_d;
    logic [DATA_WIDTH-1:0]             best_val_q, best_val_d;
    logic                              valid_q,    valid_d;
    logic [IDX_WIDTH-1:0]              idx_q,      idx_d;
    logic [DATA_WIDTH-1:0]             score_q,    score_d;
    logic [DROP_WIDTH-1:0]             drop_q,     drop_d;

    logic                  done_rise;
    logic                  capture;
    logic                  drop;
    logic [DATA_WIDTH-1:0] cand;

    // Strict sign-magnitude greater-than. A zero magnitude is treated as
    // positive so +0 and -0 compare equal.
    function automatic logic sm_gt(input logic [DATA_WIDTH-1:0] a,
                                   input logic [DATA_WIDTH-1:0] b);
        logic          a_neg, b_neg;
        logic [DATA_WIDTH-2:0] a_mag, b_mag;
        a_mag = a[DATA_WIDTH-2:0];
        b_mag = b[DATA_WIDTH-2:0];
        a_neg = a[DATA_WIDTH-1] & (a_mag != '0);
        b_neg = b[DATA_WIDTH-1] & (b_mag != '0);
        if (a_neg != b_neg) return b_neg;
        if (a_neg)          return a_mag < b_mag;
        return a_mag > b_mag;
    endfunction

    assign done_rise = done_flag & ~done_prev_q;
    assign cand      = cap_q[scan_idx_q];

    // Next-state: capture on a rise when free, scan one entry per cycle,
    // hold the result until accepted, and count frames that arrive while busy.
    always_comb begin
        state_d    = state_q;
        cap_d      = cap_q;
        scan_idx_d = scan_idx_q;
        best_idx_d = best_idx_q;
        best_val_d = best_val_q;
        valid_d    = valid_q;
        idx_d      = idx_q;
        score_d    = score_q;
        drop_d     = drop_q;
        capture    = 1'b0;
        drop       = 1'b0;
        case (state_q)
            S_IDLE: capture = done_rise;
            S_SCAN: begin
                drop = done_rise;
                if (sm_gt(cand, best_val_q)) begin
                    best_idx_d = scan_idx_q;
                    best_val_d = cand;
                end
                if (scan_idx_q == LAST_IDX) begin
                    state_d = S_OUT;
                    valid_d = 1'b1;
                    idx_d   = best_idx_d;
                    score_d = best_val_d;
                end else begin
                    scan_idx_d = scan_idx_q + IDX_WIDTH'(1);
                end
            end
            S_OUT: begin
                if (class_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                    capture = done_rise;
                end else begin
                    drop = done_rise;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A frame landing on the accepting edge goes straight into a new scan.
        if (capture) begin
            cap_d      = logits;
            best_idx_d = '0;
            best_val_d = logits[DATA_WIDTH-1:0];
            scan_idx_d = IDX_WIDTH'(1);
            state_d    = S_SCAN;
        end
        if (drop && (drop_q != '1)) drop_d = drop_q + DROP_WIDTH'(1);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            done_prev_q <= 1'b0;
            cap_q       <= '0;
            scan_idx_q  <= '0;
            best_idx_q  <= '0;
            best_val_q  <= '0;
            valid_q     <= 1'b0;
            idx_q       <= '0;
            score_q     <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            done_prev_q <= done_flag;
            cap_q       <= cap_d;
            scan_idx_q  <= scan_idx_d;
            best_idx_q  <= best_idx_d;
            best_val_q  <= best_val_d;
            valid_q     <= valid_d;
            idx_q       <= idx_d;
            score_q     <= score_d;
            drop_q      <= drop_d;
        end
    end

    assign class_valid = valid_q;
    assign class_idx   = idx_q;
    assign class_score = score_q;
    assign busy        = (state_q != S_IDLE);
    assign drop_count  = drop_q;

endmodule
